// File: rtl/d_wb_stage.sv
// Writeback stage: retires EX/MEM ops into the register file, waiting on data-memory responses for loads.
// Optional macro D_WB_INSTRET_EN builds the 32-bit retired-op counter; otherwise instret is tied to zero.
module d_wb_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_result,
  input  logic          in_is_load,
  input  logic [2:0]    in_funct3,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] busw,
  output logic [RW-1:0] rw,
  output logic          we,
  output logic          pend_valid,
  output logic [RW-1:0] pend_rd,
  output logic          err_misalign,
  output logic [31:0]   instret
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    off_q, off_d;
  logic [DW-1:0] busw_q, busw_d;
  logic [RW-1:0] rw_q, rw_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic          accept;
  logic          resp;
  logic          retire;
  logic [DW-1:0] byte_shift;
  logic [DW-1:0] half_shift;
  logic [DW-1:0] load_data;
  logic          load_bad;

  assign accept = in_valid && in_ready;
  assign resp   = (state_q == WAIT_MEM) && mem_rvalid;
  assign retire = (accept && !in_is_load) || resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && in_is_load) state_d = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid)           state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state_q == IDLE);
    pend_valid = (state_q == WAIT_MEM);
  end

  // Load data extraction from the aligned memory word using the latched byte offset
  always_comb begin
    byte_shift = mem_rdata >> {off_q, 3'b000};
    half_shift = mem_rdata >> {off_q[1], 4'b0000};
    load_data  = mem_rdata;
    load_bad   = 1'b0;
    case (funct3_q)
      3'b000:  load_data = {{(DW-8){byte_shift[7]}}, byte_shift[7:0]};
      3'b100:  load_data = {{(DW-8){1'b0}}, byte_shift[7:0]};
      3'b001: begin
        load_data = {{(DW-16){half_shift[15]}}, half_shift[15:0]};
        load_bad  = off_q[0];
      end
      3'b101: begin
        load_data = {{(DW-16){1'b0}}, half_shift[15:0]};
        load_bad  = off_q[0];
      end
      3'b010:  load_bad = (off_q != 2'b00);
      default: load_bad = 1'b1;
    endcase
  end

  always_comb begin
    rd_d     = rd_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    busw_d   = busw_q;
    rw_d     = rw_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    if (accept && in_is_load) begin
      rd_d     = in_rd;
      funct3_d = in_funct3;
      off_d    = in_result[1:0];
    end else if (accept) begin
      busw_d = in_result;
      rw_d   = in_rd;
      we_d   = (in_rd != '0);
    end else if (resp) begin
      busw_d = load_data;
      rw_d   = rd_q;
      we_d   = (rd_q != '0) && !load_bad;
      err_d  = load_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      busw_q   <= '0;
      rw_q     <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      busw_q   <= busw_d;
      rw_q     <= rw_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  assign busw         = busw_q;
  assign rw           = rw_q;
  assign we           = we_q;
  assign err_misalign = err_q;
  assign pend_rd      = rd_q;

`ifdef D_WB_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = 32'h0;
`endif

endmodule

// File: tb/tb_d_wb_stage.sv
// Directed bench for d_wb_stage: non-loads, each load type, misalignment, x0, reset mid-load, instret wrap.
module tb_d_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] busw;
  logic [4:0]  rw;
  logic        we;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        err_misalign;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'h0;

  always #5 clk = ~clk;

  d_wb_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busw(busw), .rw(rw), .we(we),
    .pend_valid(pend_valid), .pend_rd(pend_rd),
    .err_misalign(err_misalign), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_ir();
`ifdef D_WB_INSTRET_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic present(input logic [4:0] rd, input logic [31:0] res,
                         input logic ld, input logic [2:0] f3);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_result  = res;
    in_is_load = ld;
    in_funct3  = f3;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0;
    in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_busw", busw, 32'd0);
    chk("rst_rw", {27'd0, rw}, 32'd0);
    chk("rst_pend", {31'd0, pend_valid}, 32'd0);
    chk("rst_err", {31'd0, err_misalign}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instret", instret, 32'd0);

    // Non-load, one-cycle latency
    present(5'd5, 32'hDEADBEEF, 1'b0, 3'b000);
    tick(); idle_in(); exp_cnt++;
    chk("nl_we", {31'd0, we}, 32'd1);
    chk("nl_rw", {27'd0, rw}, 32'd5);
    chk("nl_busw", busw, 32'hDEADBEEF);
    chk("nl_instret", instret, exp_ir());
    tick();
    chk("nl_we_drop", {31'd0, we}, 32'd0);

    // Back-to-back non-loads
    present(5'd1, 32'h11, 1'b0, 3'b000);
    tick(); exp_cnt++;
    present(5'd2, 32'h22, 1'b0, 3'b000);
    chk("b2b1_rw", {27'd0, rw}, 32'd1);
    chk("b2b1_busw", busw, 32'h11);
    tick(); idle_in(); exp_cnt++;
    chk("b2b2_we", {31'd0, we}, 32'd1);
    chk("b2b2_busw", busw, 32'h22);
    chk("b2b_instret", instret, exp_ir());

    // lb offset 2; a stray rvalid in the accept cycle must be ignored
    present(5'd7, 32'h0000_1002, 1'b1, 3'b000);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    tick(); idle_in(); mem_rvalid = 1'b0;
    chk("lb_pend", {31'd0, pend_valid}, 32'd1);
    chk("lb_pend_rd", {27'd0, pend_rd}, 32'd7);
    chk("lb_ready", {31'd0, in_ready}, 32'd0);
    chk("lb_we_wait", {31'd0, we}, 32'd0);
    tick(); tick();
    chk("lb_pend_hold", {31'd0, pend_valid}, 32'd1);
    respond(32'h12F45678); exp_cnt++;
    chk("lb_we", {31'd0, we}, 32'd1);
    chk("lb_busw", busw, 32'hFFFFFFF4);
    chk("lb_rw", {27'd0, rw}, 32'd7);
    chk("lb_pend_drop", {31'd0, pend_valid}, 32'd0);
    chk("lb_ready_back", {31'd0, in_ready}, 32'd1);
    chk("lb_instret", instret, exp_ir());
    tick();
    chk("lb_we_drop", {31'd0, we}, 32'd0);

    // lhu offset 2
    present(5'd8, 32'h0000_0002, 1'b1, 3'b101);
    tick(); idle_in();
    respond(32'h8001_0000); exp_cnt++;
    chk("lhu_busw", busw, 32'h00008001);
    chk("lhu_we", {31'd0, we}, 32'd1);

    // lh offset 0, sign-extended
    present(5'd3, 32'h0000_0000, 1'b1, 3'b001);
    tick(); idle_in();
    respond(32'h0000_8001); exp_cnt++;
    chk("lh_busw", busw, 32'hFFFF8001);

    // lbu offset 3, zero-extended
    present(5'd4, 32'h0000_0003, 1'b1, 3'b100);
    tick(); idle_in();
    respond(32'h80FF_FFFF); exp_cnt++;
    chk("lbu_busw", busw, 32'h00000080);

    // lw offset 0
    present(5'd6, 32'h0000_0100, 1'b1, 3'b010);
    tick(); idle_in();
    respond(32'hCAFE_F00D); exp_cnt++;
    chk("lw_busw", busw, 32'hCAFEF00D);
    chk("lw_err", {31'd0, err_misalign}, 32'd0);

    // lw offset 1: misaligned
    present(5'd9, 32'h0000_0001, 1'b1, 3'b010);
    tick(); idle_in();
    respond(32'h1234_5678); exp_cnt++;
    chk("lwmis_err", {31'd0, err_misalign}, 32'd1);
    chk("lwmis_we", {31'd0, we}, 32'd0);
    chk("lwmis_rw", {27'd0, rw}, 32'd9);
    chk("lwmis_instret", instret, exp_ir());
    tick();
    chk("lwmis_err_drop", {31'd0, err_misalign}, 32'd0);

    // lh offset 1: misaligned
    present(5'd10, 32'h0000_0001, 1'b1, 3'b001);
    tick(); idle_in();
    respond(32'h1234_5678); exp_cnt++;
    chk("lhmis_err", {31'd0, err_misalign}, 32'd1);
    chk("lhmis_we", {31'd0, we}, 32'd0);

    // Illegal funct3 011
    present(5'd11, 32'h0000_0000, 1'b1, 3'b011);
    tick(); idle_in();
    respond(32'h1234_5678); exp_cnt++;
    chk("ill_err", {31'd0, err_misalign}, 32'd1);
    chk("ill_we", {31'd0, we}, 32'd0);

    // rd=0 non-load and load: no write, still counts
    present(5'd0, 32'h5555_5555, 1'b0, 3'b000);
    tick(); idle_in(); exp_cnt++;
    chk("x0_we", {31'd0, we}, 32'd0);
    chk("x0_instret", instret, exp_ir());
    present(5'd0, 32'h0000_0000, 1'b1, 3'b010);
    tick(); idle_in();
    respond(32'h7777_7777); exp_cnt++;
    chk("x0ld_we", {31'd0, we}, 32'd0);
    chk("x0ld_instret", instret, exp_ir());

    // Reset while waiting abandons the load; the late response is ignored
    present(5'd12, 32'h0000_0000, 1'b1, 3'b010);
    tick(); idle_in();
    chk("rw_pend", {31'd0, pend_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_cnt = 32'h0;
    chk("rw_pend_clr", {31'd0, pend_valid}, 32'd0);
    chk("rw_ready", {31'd0, in_ready}, 32'd1);
    respond(32'h9999_9999);
    chk("rw_late_we", {31'd0, we}, 32'd0);
    chk("rw_late_rw", {27'd0, rw}, 32'd0);
    chk("rw_instret", instret, exp_ir());

    // instret wrap
`ifdef D_WB_INSTRET_EN
    dut.instret_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    present(5'd13, 32'h0000_0013, 1'b0, 3'b000);
    tick(); idle_in(); exp_cnt++;
    chk("wrap_we", {31'd0, we}, 32'd1);
    chk("wrap_instret", instret, 32'h0);
    chk("wrap_model", instret, exp_ir());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
